// File: rtl/coherent_dcache.sv
// coherent_dcache: per-core L1 data cache. It is direct-mapped, holds one
// 2-word block per frame, and keeps the frames coherent with MSI states.
//
// Ports:
//   CLK, nRST                 clock; asynchronous active-low reset
//   dmemREN/WEN/addr/store    datapath request, held stable until dhit
//   dmemload, dhit            datapath read data / request completed
//   halt, flushed             start the dirty writeback scan / scan finished
//   dREN, dWEN, daddr, dstore block fill, writeback and snoop-supply port
//   dload, dwait              fill data; the bus word is not done yet
//   cctrans, ccwrite          coherent fill (BusRd/BusRdX), or snoop hit in M
//   ccwait, ccinv, ccsnoopaddr snoop from the other core
module coherent_dcache #(
   parameter int SETS  = 16,
   parameter int CPUID = 0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        halt,
   output logic [31:0] dmemload,
   output logic        dhit,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic [31:0] dload,
   input  logic        dwait,
   output logic        cctrans,
   output logic        ccwrite,
   input  logic        ccwait,
   input  logic        ccinv,
   input  logic [31:0] ccsnoopaddr
);

   localparam int IW = $clog2(SETS);
   localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;

   typedef enum logic [3:0] {
      IDLE, WB0, WB1, FILL0, FILL1, SNP0, SNP1, FLUSH, FWB0, FWB1, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] flush_idx_q, flush_idx_d;

   logic [24:0]   frame_tag_q [SETS];
   logic [31:0]   frame_w0_q  [SETS];
   logic [31:0]   frame_w1_q  [SETS];
   logic [1:0]    frame_st_q  [SETS];

   // Single frame write port: at most one frame changes per cycle.
   logic [IW-1:0] wr_idx;
   logic          wr_st_en, wr_tag_en, wr_w0_en, wr_w1_en;
   logic [1:0]    wr_st;
   logic [31:0]   wr_w0, wr_w1;

   logic [24:0]   req_tag, snp_tag;
   logic [IW-1:0] req_idx, snp_idx, wb_idx;
   logic          req_off, req_hit, snp_hit, snp_m, snoop_ok;
   logic [31:0]   req_word;
   logic          unused_bits;

   assign req_tag  = dmemaddr[31:7];
   assign req_idx  = dmemaddr[6:3];
   assign req_off  = dmemaddr[2];
   assign snp_tag  = ccsnoopaddr[31:7];
   assign snp_idx  = ccsnoopaddr[6:3];
   assign req_hit  = (frame_st_q[req_idx] != ST_I) && (frame_tag_q[req_idx] == req_tag);
   assign snp_hit  = (frame_st_q[snp_idx] != ST_I) && (frame_tag_q[snp_idx] == snp_tag);
   assign snp_m    = snp_hit && (frame_st_q[snp_idx] == ST_M);
   assign req_word = req_off ? frame_w1_q[req_idx] : frame_w0_q[req_idx];
   // The flush writeback walks the scan counter; a miss writeback uses the request index.
   assign wb_idx   = ((state_q == FWB0) || (state_q == FWB1)) ? flush_idx_q : req_idx;
   // Snoops take priority over datapath service wherever the cache is otherwise idle.
   assign snoop_ok = ccwait && ((state_q == IDLE) || (state_q == FLUSH) || (state_q == DONE));
   assign flushed  = (state_q == DONE);
   assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[2:0], 32'(CPUID)};

   // Next-state, output and frame-update decode
   always_comb begin
      state_d     = state_q;
      flush_idx_d = flush_idx_q;
      dhit        = 1'b0;
      dmemload    = 32'h0;
      dREN        = 1'b0;
      dWEN        = 1'b0;
      daddr       = 32'h0;
      dstore      = 32'h0;
      cctrans     = 1'b0;
      ccwrite     = 1'b0;
      wr_idx      = req_idx;
      wr_st_en    = 1'b0;
      wr_st       = ST_I;
      wr_tag_en   = 1'b0;
      wr_w0_en    = 1'b0;
      wr_w1_en    = 1'b0;
      wr_w0       = dload;
      wr_w1       = dload;
      if (snoop_ok) begin
         if (snp_m) begin
            cctrans = 1'b1;
            state_d = SNP0;
         end else if (snp_hit && ccinv) begin
            wr_idx   = snp_idx;
            wr_st_en = 1'b1;
            wr_st    = ST_I;
         end else begin
            state_d = state_q;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (halt) begin
                  state_d = FLUSH;
               end else if (dmemREN && req_hit) begin
                  dhit     = 1'b1;
                  dmemload = req_word;
               end else if (dmemWEN && req_hit && (frame_st_q[req_idx] == ST_M)) begin
                  dhit     = 1'b1;
                  wr_w0    = dmemstore;
                  wr_w1    = dmemstore;
                  wr_w0_en = ~req_off;
                  wr_w1_en = req_off;
               end else if (dmemREN || dmemWEN) begin
                  if (!req_hit && (frame_st_q[req_idx] == ST_M)) begin
                     state_d = WB0;
                  end else begin
                     // Clean victim or S upgrade: drop the frame so that the fill
                     // can overwrite it word by word.
                     wr_st_en = 1'b1;
                     wr_st    = ST_I;
                     state_d  = FILL0;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            WB0, FWB0: begin
               dWEN   = 1'b1;
               daddr  = {frame_tag_q[wb_idx], wb_idx, 1'b0, 2'b00};
               dstore = frame_w0_q[wb_idx];
               if (!dwait) begin
                  state_d = (state_q == WB0) ? WB1 : FWB1;
               end else begin
                  state_d = state_q;
               end
            end
            WB1, FWB1: begin
               dWEN   = 1'b1;
               daddr  = {frame_tag_q[wb_idx], wb_idx, 1'b1, 2'b00};
               dstore = frame_w1_q[wb_idx];
               if (!dwait) begin
                  wr_idx   = wb_idx;
                  wr_st_en = 1'b1;
                  wr_st    = ST_I;
                  state_d  = (state_q == WB1) ? FILL0 : FLUSH;
               end else begin
                  state_d = state_q;
               end
            end
            FILL0, FILL1: begin
               dREN    = 1'b1;
               cctrans = 1'b1;
               ccwrite = dmemWEN;
               daddr   = {req_tag, req_idx, (state_q == FILL1), 2'b00};
               if (!dwait) begin
                  if (state_q == FILL0) begin
                     wr_w0_en = 1'b1;
                     state_d  = FILL1;
                  end else begin
                     wr_w1_en  = 1'b1;
                     wr_tag_en = 1'b1;
                     wr_st_en  = 1'b1;
                     wr_st     = dmemWEN ? ST_M : ST_S;
                     state_d   = IDLE;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            SNP0, SNP1: begin
               cctrans = 1'b1;
               daddr   = {snp_tag, snp_idx, (state_q == SNP1), 2'b00};
               dstore  = (state_q == SNP1) ? frame_w1_q[snp_idx] : frame_w0_q[snp_idx];
               if (!dwait) begin
                  if (state_q == SNP0) begin
                     state_d = SNP1;
                  end else begin
                     wr_idx   = snp_idx;
                     wr_st_en = 1'b1;
                     wr_st    = ccinv ? ST_I : ST_S;
                     state_d  = IDLE;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            FLUSH: begin
               // A written-back frame is I on return, so it is skipped next visit.
               if (frame_st_q[flush_idx_q] == ST_M) begin
                  state_d = FWB0;
               end else if (flush_idx_q == IW'(SETS - 1)) begin
                  state_d = DONE;
               end else begin
                  flush_idx_d = flush_idx_q + {{(IW-1){1'b0}}, 1'b1};
               end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Controller state and flush scan counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         flush_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_idx_q <= flush_idx_d;
      end
   end

   // Coherence state per frame; reset invalidates every frame
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < SETS; i++) frame_st_q[i] <= ST_I;
      end else if (wr_st_en) begin
         frame_st_q[wr_idx] <= wr_st;
      end
   end

   // Tag and data storage; contents are meaningless while the frame is I
   always_ff @(posedge CLK) begin
      if (wr_tag_en) frame_tag_q[wr_idx] <= req_tag;
      if (wr_w0_en)  frame_w0_q[wr_idx]  <= wr_w0;
      if (wr_w1_en)  frame_w1_q[wr_idx]  <= wr_w1;
   end

endmodule

// File: tb/tb_coherent_dcache.sv
module tb_coherent_dcache;
   logic        CLK = 1'b0;
   logic        nRST;
   logic        dmemREN, dmemWEN, halt, dwait, ccwait, ccinv;
   logic [31:0] dmemaddr, dmemstore, dload, ccsnoopaddr;
   logic [31:0] dmemload, daddr, dstore;
   logic        dhit, flushed, dREN, dWEN, cctrans, ccwrite;

   int checks = 0;
   int passes = 0;

   coherent_dcache #(.SETS(16), .CPUID(0)) dut (
      .CLK(CLK), .nRST(nRST),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .halt(halt), .dmemload(dmemload), .dhit(dhit), .flushed(flushed),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait), .cctrans(cctrans), .ccwrite(ccwrite),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Called in the FILL0 cycle; leaves the bench in the following IDLE cycle.
   task automatic fill(input string tag, input logic [31:0] base, input logic [31:0] w0,
                       input logic [31:0] w1, input logic wr);
      dload = w0;
      #1;
      chk({tag, "_f0_ctl"}, {28'h0, dREN, cctrans, ccwrite, dWEN}, {28'h0, 1'b1, 1'b1, wr, 1'b0});
      chk({tag, "_f0_addr"}, daddr, base);
      tick;
      dload = w1;
      #1;
      chk({tag, "_f1_ctl"}, {30'h0, dREN, cctrans}, 32'h3);
      chk({tag, "_f1_addr"}, daddr, base + 32'h4);
      tick;
   endtask

   initial begin
      logic [31:0] wa [4];
      logic [31:0] wd [4];
      int nw;
      int bus_bad;
      logic done;

      nRST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; dwait = 1'b0;
      ccwait = 1'b0; ccinv = 1'b0; dmemaddr = 32'h0; dmemstore = 32'h0;
      dload = 32'h0; ccsnoopaddr = 32'h0;
      #2 nRST = 1'b0;
      #1;
      chk("rst_ctl", {26'h0, dREN, dWEN, cctrans, ccwrite, dhit, flushed}, 32'h0);
      chk("rst_daddr", daddr, 32'h0);
      chk("rst_dstore", dstore, 32'h0);
      chk("rst_dmemload", dmemload, 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      tick;

      // Cold read of 0x40 fills frame 8 in S; one stalled fill cycle first.
      dmemREN = 1'b1; dmemaddr = 32'h40;
      #1;
      chk("cold_miss_dhit", {31'h0, dhit}, 32'h0);
      chk("cold_idle_bus", {30'h0, dREN, dWEN}, 32'h0);
      tick;
      dwait = 1'b1;
      #1;
      chk("stall_addr", daddr, 32'h40);
      tick;
      dwait = 1'b0;
      fill("cold", 32'h40, 32'h11, 32'h22, 1'b0);
      #1;
      chk("cold_hit", {31'h0, dhit}, 32'h1);
      chk("cold_load", dmemload, 32'h11);
      tick;
      dmemaddr = 32'h44;
      #1;
      chk("cold_load_w1", dmemload, 32'h22);
      tick;

      // Write to S frame is an upgrade fill with ccwrite.
      dmemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h44; dmemstore = 32'hAA;
      #1;
      chk("upg_no_hit", {31'h0, dhit}, 32'h0);
      tick;
      fill("upg", 32'h40, 32'h11, 32'h22, 1'b1);
      #1;
      chk("upg_hit", {31'h0, dhit}, 32'h1);
      tick;
      dmemWEN = 1'b0; dmemREN = 1'b1;
      #1;
      chk("upg_readback", dmemload, 32'hAA);
      tick;

      // Conflict read of 0xC0 writes back the M victim first.
      dmemaddr = 32'hC0;
      #1;
      chk("conf_no_hit", {31'h0, dhit}, 32'h0);
      tick;
      #1;
      chk("wb0_ctl", {30'h0, dWEN, dREN}, 32'h2);
      chk("wb0_addr", daddr, 32'h40);
      chk("wb0_data", dstore, 32'h11);
      tick;
      #1;
      chk("wb1_addr", daddr, 32'h44);
      chk("wb1_data", dstore, 32'hAA);
      tick;
      fill("conf", 32'hC0, 32'h33, 32'h44, 1'b0);
      #1;
      chk("conf_load", dmemload, 32'h33);
      tick;

      // Write 0x44 again: S victim needs no writeback, frame 8 becomes M {0x11,0xAA}.
      dmemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h44; dmemstore = 32'hAA;
      #1;
      tick;
      fill("remod", 32'h40, 32'h11, 32'h22, 1'b1);
      #1;
      chk("remod_hit", {31'h0, dhit}, 32'h1);
      tick;

      // Snoop read hits M: supply both words, drop to S, datapath stalls meanwhile.
      dmemWEN = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h40;
      ccwait = 1'b1; ccsnoopaddr = 32'h44; ccinv = 1'b0;
      #1;
      chk("snp_idle_ctl", {30'h0, cctrans, dhit}, 32'h2);
      tick;
      #1;
      chk("snp0_ctl", {29'h0, cctrans, dWEN, dhit}, 32'h4);
      chk("snp0_addr", daddr, 32'h40);
      chk("snp0_data", dstore, 32'h11);
      tick;
      #1;
      chk("snp1_addr", daddr, 32'h44);
      chk("snp1_data", dstore, 32'hAA);
      chk("snp1_dhit", {31'h0, dhit}, 32'h0);
      tick;
      ccwait = 1'b0;
      #1;
      chk("post_snp_load", dmemload, 32'h11);
      chk("post_snp_hit", {31'h0, dhit}, 32'h1);
      tick;

      // Invalidating snoop on S frame: no cctrans, then the read misses.
      ccwait = 1'b1; ccinv = 1'b1;
      #1;
      chk("inv_ctl", {30'h0, cctrans, dhit}, 32'h0);
      tick;
      ccwait = 1'b0; ccinv = 1'b0;
      #1;
      chk("inv_miss", {31'h0, dhit}, 32'h0);
      tick;
      fill("inv", 32'h40, 32'h55, 32'h66, 1'b0);
      #1;
      chk("inv_refill", dmemload, 32'h55);
      tick;

      // Frames 2 and 9 in M: {0xB0,0x02} and {0x03,0xC9}.
      dmemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h10; dmemstore = 32'hB0;
      #1;
      tick;
      fill("f2", 32'h10, 32'h01, 32'h02, 1'b1);
      tick;
      dmemaddr = 32'h4C; dmemstore = 32'hC9;
      #1;
      tick;
      fill("f9", 32'h48, 32'h03, 32'h04, 1'b1);
      tick;

      // Flush.
      dmemWEN = 1'b0; halt = 1'b1;
      #1;
      chk("pre_flushed", {31'h0, flushed}, 32'h0);
      nw = 0; bus_bad = 0; done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         #1;
         if (flushed) begin
            done = 1'b1;
         end else begin
            if (dWEN) begin
               if (nw < 4) begin
                  wa[nw] = daddr;
                  wd[nw] = dstore;
               end
               nw++;
            end
            if (dREN || cctrans) bus_bad++;
            tick;
         end
      end
      chk("flush_done", {31'h0, done}, 32'h1);
      chk("flush_words", nw, 32'd4);
      chk("flush_rd", bus_bad, 32'd0);
      chk("fwb_a0", wa[0], 32'h10);
      chk("fwb_d0", wd[0], 32'hB0);
      chk("fwb_a1", wa[1], 32'h14);
      chk("fwb_d1", wd[1], 32'h02);
      chk("fwb_a2", wa[2], 32'h48);
      chk("fwb_d2", wd[2], 32'h03);
      chk("fwb_a3", wa[3], 32'h4C);
      chk("fwb_d3", wd[3], 32'hC9);
      for (int i = 0; i < 3; i++) begin
         tick;
         #1;
         chk("done_quiet", {28'h0, dREN, dWEN, cctrans, flushed}, 32'h1);
      end
      nRST = 1'b0;
      #1;
      chk("rst_flushed", {31'h0, flushed}, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
